pwm_multi: RTL and testbench

- Parametrised multi-channel successor to the team's single-channel duty-cycle PWM.
- One shared period counter drives CHANNELS independent compare outputs.
- Adds a programmable period, a clock prescaler, and edge- or centre-aligned counting.
- Duty values are double-buffered, so updates never glitch a running period; outputs drive uo_out pins at the tile top level.

---
 rtl/pwm_multi.sv | 152 +++++++++++++++
 tb/tb_pwm_multi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with one shared period counter.
// A prescaler generates count ticks; the counter runs edge-aligned (0..TOP)
// or centre-aligned (0..TOP..1). Duty values are written into shadow
// registers and copied into the active set only at a period boundary.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_UP   | counter incrementing (always the state in edge mode)
// ST_DOWN | centre mode, counter decrementing back toward the boundary
module pwm_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  center_mode,
  input  logic [CHANNELS-1:0]   ch_en,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start
);

  typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} dir_t;

  dir_t                  state_q, state_d;
  logic [PRESCALE_W-1:0] pcnt_q;
  logic                  tick;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  mode_q;
  logic                  boundary;
  logic                  boundary_q;
  logic [WIDTH-1:0]      shadow_q [CHANNELS];
  logic [WIDTH-1:0]      active_q [CHANNELS];
  logic [CHANNELS-1:0]   pwm_d;

  assign tick = (pcnt_q == prescale);

  // Prescaler: wraps to 0 on the clock where it matches prescale.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  // State register: direction, counter value and latched alignment mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_UP;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (boundary) begin
        mode_q <= center_mode;
      end
    end
  end

  // Next-state: advance the counter on each tick; >= compares absorb a
  // period that was lowered below the current count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (!mode_q) begin
        state_d = ST_UP;
        cnt_d   = (cnt_q >= period) ? '0 : cnt_q + 1'b1;
      end else if (state_q == ST_UP) begin
        if (cnt_q >= period) begin
          if (period == '0) begin
            cnt_d = '0;
          end else begin
            state_d = ST_DOWN;
            cnt_d   = cnt_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // cnt<=1 also catches a reversal that landed directly on 0
        if (cnt_q <= WIDTH'(1)) begin
          state_d = ST_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // Output decode: boundary tick and per-channel compare on pre-edge values.
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (!mode_q) begin
        boundary = (cnt_q >= period);
      end else if (state_q == ST_UP) begin
        boundary = (cnt_q >= period) && (period == '0);
      end else begin
        boundary = (cnt_q <= WIDTH'(1));
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = ch_en[i] & (active_q[i] > cnt_q);
    end
  end

  // Duty registers: shadow takes writes, active reloads at each boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary) begin
          active_q[i] <= shadow_q[i];
        end
        if (wr_en && (32'(wr_ch) == i)) begin
          shadow_q[i] <= wr_duty;
        end
      end
    end
  end

  // Registered outputs; period_start lands with the first sample of the
  // new period, one edge after the boundary tick itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out      <= '0;
      boundary_q   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= pwm_d;
      boundary_q   <= boundary;
      period_start <= boundary_q;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed stimulus timeline with a scoreboard queue of
// expected {period_start, pwm_out} samples keyed by negedge cycle number.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_duty;
  logic [7:0] period;
  logic [7:0] prescale;
  logic       center_mode;
  logic [3:0] ch_en;
  logic [3:0] pwm_out;
  logic       period_start;

  pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .period(period), .prescale(prescale),
    .center_mode(center_mode), .ch_en(ch_en), .pwm_out(pwm_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [4:0] exp;
    logic [4:0] mask;
    string      name;
  } exp_t;

  exp_t q[$];
  int   mcyc    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every negedge is one output sample; pop matching expectations.
  always @(negedge clk) begin
    logic [4:0] obs;
    mcyc = mcyc + 1;
    obs  = {period_start, pwm_out};
    while (q.size() > 0 && q[0].at <= mcyc) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (e.at < mcyc) begin
        n_fail++;
        $display("FAIL %s cycle %0d: sample missed (now %0d)", e.name, e.at, mcyc);
      end else if ((obs & e.mask) !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got {ps,pwm}=%b want %b (mask %b)",
                 e.name, e.at, obs, e.exp, e.mask);
      end
    end
  end

  task automatic push(input int at, input logic [4:0] exp, input logic [4:0] mask,
                      input string name);
    exp_t e;
    e.at = at; e.exp = exp; e.mask = mask; e.name = name;
    q.push_back(e);
  endtask

  // One full period of samples. Count seen at sample j is j in edge mode and
  // the triangle 0..per..1 in centre mode; enable switches from en_a to en_b at j=sw.
  task automatic push_period(input int base, input int len, input int per,
                             input bit centre, input int d0, input int d1,
                             input int d2, input int d3, input logic [3:0] en_a,
                             input logic [3:0] en_b, input int sw, input string name);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int j = 0; j < len; j++) begin
      int c;
      logic [4:0] ex;
      logic [3:0] en;
      c  = (centre && j > per) ? (2 * per - j) : j;
      en = (j < sw) ? en_a : en_b;
      for (int i = 0; i < 4; i++) ex[i] = en[i] && (d[i] > c);
      ex[4] = (j == 0);
      push(base + j, ex, 5'h1f, name);
    end
  endtask

  task automatic wait_to(input int t);
    while (mcyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_duty = 8'(duty);
  endtask

  initial begin
    int guard;
    reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    period = 8'd9; prescale = 8'd0; center_mode = 1'b0; ch_en = 4'hf;

    // Edge mode, period 9: reset, first periods, ch_en drop, shadow updates,
    // deferred centre switch.
    wait_to(2);
    push(3, 5'b0, 5'h1f, "reset_state");
    push(4, 5'b0, 5'h1f, "reset_state");
    push(9, 5'b0, 5'h1f, "pre_boundary");
    push_period(15, 10, 9, 0, 3, 0, 10, 255, 4'hf, 4'hf, 10, "edge_p1");
    push_period(25, 10, 9, 0, 3, 0, 10, 255, 4'hf, 4'h7, 5,  "ch_en_off");
    push_period(35, 10, 9, 0, 3, 0, 10, 255, 4'hf, 4'hf, 10, "mid_write_hold");
    push_period(45, 10, 9, 0, 7, 0, 10, 255, 4'hf, 4'hf, 10, "mid_write_next");
    push_period(55, 10, 9, 0, 7, 0, 10, 255, 4'hf, 4'hf, 10, "bnd_write_hold");
    push_period(65, 10, 9, 0, 5, 0, 10, 255, 4'hf, 4'hf, 10, "bnd_write_next");
    push_period(75, 8,  4, 1, 2, 0, 10, 255, 4'hf, 4'hf, 8,  "centre_p1");
    push_period(83, 4,  4, 1, 2, 0, 10, 255, 4'hf, 4'hf, 4,  "centre_p2");

    wait_to(4);  reset = 1'b0; wr(0, 3);
    wait_to(5);  wr(1, 0);
    wait_to(6);  wr(2, 10);
    wait_to(7);  wr(3, 255);
    wait_to(8);  wr_en = 1'b0;
    wait_to(29); ch_en = 4'h7;
    wait_to(34); ch_en = 4'hf;
    wait_to(38); wr(0, 7);
    wait_to(39); wr_en = 1'b0;
    wait_to(53); wr(0, 5);
    wait_to(54); wr_en = 1'b0;
    wait_to(67); center_mode = 1'b1; wr(0, 2);
    wait_to(68); wr_en = 1'b0;
    wait_to(73); period = 8'd4;

    // Mid-period reset clears outputs and duties; outputs stay low after.
    wait_to(86);
    push(87, 5'b0, 5'h1f, "reset_mid");
    for (int c = 88; c <= 98; c++) push(c, 5'b0, 5'h0f, "reset_stays_low");
    reset = 1'b1;
    wait_to(87); reset = 1'b0;

    // Prescale 3, period 1, duty 1; then period 9 dropped to 2 at cnt=6.
    wait_to(99);
    reset = 1'b1; prescale = 8'd3; period = 8'd1; center_mode = 1'b0;
    for (int c = 101; c <= 160; c++) begin
      logic ps, hi;
      ps = (c == 109) || (c == 117) || (c == 145) || (c == 157);
      hi = (c >= 109 && c <= 112) || (c >= 117 && c <= 120) ||
           (c >= 145 && c <= 148) || (c >= 157 && c <= 160);
      push(c, {ps, 3'b000, hi}, 5'h1f, "prescale_period");
    end
    wait_to(100); reset = 1'b0; wr(0, 1);
    wait_to(101); wr_en = 1'b0;
    wait_to(117); period = 8'd9;
    wait_to(141); period = 8'd2;

    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
